// File: rtl/ft_run_monitor.sv
// Run-completion monitor for redundant cores: snoops per-channel writes, records
// result/flag words, then votes a majority result or flags a cycle-accurate timeout.
module ft_run_monitor #(
    parameter int unsigned       NUM_CH         = 3,
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] FLAG_ADDR      = 'h0000_1000,
    parameter logic [ADDR_W-1:0] RESULT_ADDR    = 'h0000_1004,
    parameter int unsigned       TIMEOUT_CYCLES = 100,
    parameter int unsigned       CNT_W          = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [NUM_CH-1:0]        wr_en_i,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [DATA_W-1:0]        result_o,
    output logic                     majority_o,
    output logic                     mismatch_o,
    output logic [CNT_W-1:0]         cycles_o
);

    // state      | meaning
    // ST_IDLE    | waiting for start_i, writes ignored
    // ST_RUN     | counting cycles, capturing results and completion flags
    // ST_DONE    | all channels flagged, verdict held until start_i
    // ST_TIMEOUT | budget expired before completion, held until start_i
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t            state_q;
    logic [DATA_W-1:0] res_q   [NUM_CH];
    logic [DATA_W-1:0] res_nxt [NUM_CH];
    logic [NUM_CH-1:0] done_set;
    logic [NUM_CH-1:0] ch_done_nxt;
    logic [DATA_W-1:0] vote_val;
    logic              vote_maj;
    logic              vote_mis;
    int unsigned       cnt;

    // Done channels are frozen, so their writes never reach the capture logic.
    always_comb begin
        done_set = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            res_nxt[k] = res_q[k];
            if (wr_en_i[k] && !ch_done_o[k]) begin
                if (wr_addr_i[k*ADDR_W +: ADDR_W] == RESULT_ADDR)
                    res_nxt[k] = wr_data_i[k*DATA_W +: DATA_W];
                if (wr_addr_i[k*ADDR_W +: ADDR_W] == FLAG_ADDR &&
                    wr_data_i[k*DATA_W +: DATA_W] != '0)
                    done_set[k] = 1'b1;
            end
        end
        ch_done_nxt = ch_done_o | done_set;
    end

    // On the completing cycle every channel is already done or is flagging,
    // so no result capture can be pending and res_q is the final set.
    always_comb begin
        vote_val = res_q[0];
        vote_maj = 1'b0;
        vote_mis = 1'b0;
        cnt      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt = 0;
            for (int j = 0; j < NUM_CH; j++)
                if (res_q[i] == res_q[j]) cnt = cnt + 1;
            if (!vote_maj && cnt > NUM_CH / 2) begin
                vote_maj = 1'b1;
                vote_val = res_q[i];
            end
        end
        for (int j = 0; j < NUM_CH; j++)
            if (res_q[j] != vote_val) vote_mis = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            ch_done_o  <= '0;
            result_o   <= '0;
            majority_o <= 1'b0;
            mismatch_o <= 1'b0;
            cycles_o   <= '0;
            for (int k = 0; k < NUM_CH; k++) res_q[k] <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycles_o  <= cycles_o + 1'b1;
                    ch_done_o <= ch_done_nxt;
                    for (int k = 0; k < NUM_CH; k++) res_q[k] <= res_nxt[k];
                    if (&ch_done_nxt) begin
                        state_q    <= ST_DONE;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        result_o   <= vote_val;
                        majority_o <= vote_maj;
                        mismatch_o <= vote_mis;
                    end else if (CNT_W'(cycles_o + 1'b1) == TO_LIM) begin
                        state_q   <= ST_TIMEOUT;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q    <= ST_RUN;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        timeout_o  <= 1'b0;
                        ch_done_o  <= '0;
                        result_o   <= '0;
                        majority_o <= 1'b0;
                        mismatch_o <= 1'b0;
                        cycles_o   <= '0;
                        for (int k = 0; k < NUM_CH; k++) res_q[k] <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_run_monitor.sv
// Directed bench for ft_run_monitor: a per-cycle behavioural model checked every
// cycle, plus hand-computed literal checks after each scenario.
module tb_ft_run_monitor;
    localparam int NUM_CH = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 100;
    localparam logic [31:0] FLAG = 32'h0000_1000;
    localparam logic [31:0] RES  = 32'h0000_1004;

    logic clk = 0;
    logic rst_n = 0;
    logic start = 0;
    logic [NUM_CH-1:0]    wr_en = '0;
    logic [NUM_CH*AW-1:0] wr_addr = '0;
    logic [NUM_CH*DW-1:0] wr_data = '0;
    logic busy, done, tmo, maj, mis;
    logic [NUM_CH-1:0] ch_done;
    logic [DW-1:0] result;
    logic [15:0] cycles;

    int total = 0;
    int bad = 0;
    int cur = 0;

    ft_run_monitor #(.NUM_CH(NUM_CH), .ADDR_W(AW), .DATA_W(DW),
                     .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .timeout_o(tmo), .ch_done_o(ch_done),
        .result_o(result), .majority_o(maj), .mismatch_o(mis), .cycles_o(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 running, 2 finished ok, 3 ran out of time.
    int          m_phase = 0;
    int          m_cycles = 0;
    bit          m_fin [NUM_CH];
    logic [31:0] m_val [NUM_CH];
    logic [31:0] m_result = 0;
    bit          m_maj = 0, m_mis = 0;

    function automatic logic [NUM_CH-1:0] m_fin_vec();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = m_fin[k];
        return v;
    endfunction

    task automatic m_clear();
        m_cycles = 0; m_result = 0; m_maj = 0; m_mis = 0;
        for (int k = 0; k < NUM_CH; k++) begin m_fin[k] = 0; m_val[k] = 0; end
    endtask

    task automatic m_vote();
        int votes;
        m_result = m_val[0];
        m_maj = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            votes = 0;
            for (int j = 0; j < NUM_CH; j++) votes += (m_val[i] == m_val[j]) ? 1 : 0;
            if (2 * votes > NUM_CH) begin m_result = m_val[i]; m_maj = 1; end
        end
        m_mis = 0;
        for (int j = 0; j < NUM_CH; j++) if (m_val[j] != m_result) m_mis = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_clear();
        end else if (m_phase == 1) begin
            m_cycles++;
            for (int k = 0; k < NUM_CH; k++)
                if (wr_en[k] && !m_fin[k]) begin
                    if (wr_addr[k*AW +: AW] == RES) m_val[k] = wr_data[k*DW +: DW];
                    if (wr_addr[k*AW +: AW] == FLAG && wr_data[k*DW +: DW] != 0) m_fin[k] = 1;
                end
            if (&m_fin_vec()) begin m_phase = 2; m_vote(); end
            else if (m_cycles == TO) m_phase = 3;
        end else if (start) begin
            m_phase = 1;
            m_clear();
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("timeout", 32'(tmo), 32'(m_phase == 3));
        chk("ch_done", 32'(ch_done), 32'(m_fin_vec()));
        chk("cycles", 32'(cycles), 32'(m_cycles));
        chk("result", result, m_result);
        chk("majority", 32'(maj), 32'(m_maj));
        chk("mismatch", 32'(mis), 32'(m_mis));
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = '0;
        start = 0;
        cur++;
    endtask

    task automatic put(int ch, logic [31:0] a, logic [31:0] d);
        wr_en[ch] = 1'b1;
        wr_addr[ch*AW +: AW] = a;
        wr_data[ch*DW +: DW] = d;
    endtask

    task automatic arm();
        start = 1;
        step();
        cur = 1;
    endtask

    task automatic goto(int n);
        while (cur < n) step();
    endtask

    task automatic vote_case(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                             logic [31:0] er, bit em, bit ex);
        arm();
        put(0, RES, a); put(1, RES, b); put(2, RES, c);
        step();
        put(0, FLAG, 1); put(1, FLAG, 1); put(2, FLAG, 1);
        step();
        chk("vote_done", 32'(done), 1);
        chk("vote_result", result, er);
        chk("vote_majority", 32'(maj), 32'(em));
        chk("vote_mismatch", 32'(mis), 32'(ex));
        chk("vote_cycles", 32'(cycles), 2);
        put(2, RES, 32'd123); put(0, FLAG, 1);
        step();
        chk("done_hold_result", result, er);
    endtask

    task automatic timeout_case(bit late_flag);
        arm();
        put(0, RES, 8); put(1, RES, 8); put(2, RES, 8);
        step();
        put(0, FLAG, 1);
        step();
        put(1, FLAG, 1);
        goto(TO);
        if (late_flag) put(2, FLAG, 1);
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cycles", 32'(cycles), 0);

        put(0, FLAG, 1); put(1, RES, 77);
        step();
        chk("idle_ignore_flag", 32'(ch_done), 0);

        // staggered flags, all agree on 42
        arm();
        put(0, RES, 42); put(1, RES, 42); put(2, RES, 42);
        goto(5); put(0, FLAG, 1);
        goto(7); put(1, FLAG, 1);
        goto(9); put(2, FLAG, 1);
        step();
        chk("a_done", 32'(done), 1);
        chk("a_result", result, 42);
        chk("a_majority", 32'(maj), 1);
        chk("a_mismatch", 32'(mis), 0);
        chk("a_cycles", 32'(cycles), 9);

        vote_case(42, 42, 17, 42, 1, 1);
        vote_case(1, 2, 3, 1, 0, 1);
        vote_case(5, 7, 7, 7, 1, 1);

        timeout_case(0);
        chk("to_timeout", 32'(tmo), 1);
        chk("to_cycles", 32'(cycles), 100);
        chk("to_ch_done", 32'(ch_done), 32'b011);
        chk("to_result", result, 0);
        chk("to_done", 32'(done), 0);

        timeout_case(1);
        chk("race_done", 32'(done), 1);
        chk("race_timeout", 32'(tmo), 0);
        chk("race_cycles", 32'(cycles), 100);
        chk("race_result", result, 8);

        // filtering: overwrite, zero flag, stray address, post-flag write
        arm();
        put(0, RES, 5);
        step();
        put(0, RES, 6);
        step();
        put(0, FLAG, 0); put(1, 32'h0000_1008, 1);
        step();
        chk("zero_flag_ignored", 32'(ch_done), 0);
        put(0, FLAG, 1); put(1, RES, 6); put(2, RES, 6);
        step();
        put(0, RES, 99);
        step();
        put(1, FLAG, 1); put(2, FLAG, 1);
        step();
        chk("filt_result", result, 6);
        chk("filt_mismatch", 32'(mis), 0);

        // re-arm from DONE, start ignored in RUN, async reset mid-run
        arm();
        chk("rearm_busy", 32'(busy), 1);
        chk("rearm_cycles", 32'(cycles), 0);
        chk("rearm_result", result, 0);
        goto(3);
        start = 1;
        step();
        chk("run_start_ignored", 32'(cycles), 3);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_cycles", 32'(cycles), 0);
        step();
        rst_n = 1;
        step();
        chk("post_reset_idle", 32'(busy), 0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
